// File: rtl/data_mem_sized_pkg.sv
// Shared constants for the sized data memory: access-size encoding and FSM state values.
package data_mem_sized_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

endpackage

// File: rtl/data_mem_sized_if.sv
// Request/response bus of the sized data memory; the requester uses master, the memory uses slave.
interface data_mem_sized_if #(
  parameter int DATA_W = 64
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [63:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_sized_mem_lane_align.sv
// Combinational lane logic: byte enables and store shift for the addressed lane,
// plus load byte selection with sign/zero extension to the full word.
module mem_lane_align
  import data_mem_sized_pkg::*;
#(
  parameter int  DATA_W = 64,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB),
  localparam int SB_W   = $clog2(DATA_W)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  lane,
  input  logic              ld_unsigned,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] rword,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] st_shifted,
  output logic [DATA_W-1:0] ld_ext
);

  logic [3:0]        nbytes_s;
  logic [NB-1:0]     bmask_s;
  logic [DATA_W-1:0] bitmask_s;
  logic [DATA_W-1:0] rshift_s;
  logic [SB_W-1:0]   sbit_s;
  logic              sign_s;

  // Access width in bytes; a full-word access clamps to the word so a 32-bit build stays in range.
  always_comb begin
    case (size)
      SZ_B:    nbytes_s = 4'd1;
      SZ_H:    nbytes_s = 4'd2;
      SZ_W:    nbytes_s = (NB >= 4) ? 4'd4 : 4'(NB);
      SZ_D:    nbytes_s = 4'(NB);
      default: nbytes_s = 4'(NB);
    endcase
  end

  // Store path: byte enables and data moved up to the addressed lane.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bmask_s[i] = (i < int'(nbytes_s));
    end
    be         = bmask_s << lane;
    st_shifted = st_data << {lane, 3'b000};
  end

  // Load path: bring the lane down to bit 0, keep the accessed bytes, fill the rest.
  always_comb begin
    rshift_s = rword >> {lane, 3'b000};
    for (int i = 0; i < DATA_W; i++) begin
      bitmask_s[i] = (i < 8 * int'(nbytes_s));
    end
    sbit_s = SB_W'(8 * int'(nbytes_s) - 1);
    sign_s = ~ld_unsigned & rshift_s[sbit_s];
    // A full-word mask leaves no fill bits, so req_unsigned has no effect there.
    ld_ext = (rshift_s & bitmask_s) | (sign_s ? ~bitmask_s : {DATA_W{1'b0}});
  end

endmodule

// File: rtl/data_mem_sized.sv
// Single-outstanding sized load/store memory: IDLE accepts, ACCESS waits READ_LAT cycles,
// RESP holds the response until it is consumed.
module data_mem_sized
  import data_mem_sized_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  data_mem_sized_if.slave bus
);

  localparam int         NB       = DATA_W / 8;
  localparam int         OFF_W    = $clog2(NB);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pend_err_q, pend_err_d;
  logic [DATA_W-1:0] pend_rdata_q, pend_rdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic              hs_s;
  logic              misaligned_s;
  logic              out_of_range_s;
  logic              illegal_size_s;
  logic              acc_err_s;
  logic              wr_en_s;
  logic [63:0]       size_mask_s;
  logic [IDX_W-1:0]  idx_s;
  logic [OFF_W-1:0]  lane_s;
  logic [DATA_W-1:0] rword_s;
  logic [NB-1:0]     be_s;
  logic [DATA_W-1:0] wdata_sh_s;
  logic [DATA_W-1:0] rdata_ext_s;

  // Request decode: any address bit above the index makes the access out of range, so nothing aliases.
  always_comb begin
    hs_s           = bus.req_valid & req_ready_q;
    idx_s          = bus.req_addr[OFF_W +: IDX_W];
    lane_s         = bus.req_addr[OFF_W-1:0];
    size_mask_s    = (64'd1 << bus.req_size) - 64'd1;
    misaligned_s   = (bus.req_addr & size_mask_s) != 64'd0;
    out_of_range_s = (bus.req_addr >> (OFF_W + IDX_W)) != 64'd0;
    illegal_size_s = (DATA_W == 32) && (bus.req_size == SZ_D);
    acc_err_s      = misaligned_s | out_of_range_s | illegal_size_s;
    wr_en_s        = hs_s & bus.req_we & ~acc_err_s & ~rst;
    rword_s        = mem_q[idx_s];
  end

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane (
    .size        (bus.req_size),
    .lane        (lane_s),
    .ld_unsigned (bus.req_unsigned),
    .st_data     (bus.req_wdata),
    .rword       (rword_s),
    .be          (be_s),
    .st_shifted  (wdata_sh_s),
    .ld_ext      (rdata_ext_s)
  );

  // Next-state and response computation; load data is captured at the handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_err_d   = pend_err_q;
    pend_rdata_d = pend_rdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          state_d      = ST_ACCESS;
          cnt_d        = CNT_INIT;
          pend_err_d   = acc_err_s;
          pend_rdata_d = (bus.req_we | acc_err_s) ? {DATA_W{1'b0}} : rdata_ext_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 2'd0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = pend_err_q;
          resp_rdata_d = pend_rdata_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = {DATA_W{1'b0}};
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = {DATA_W{1'b0}};
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      pend_err_q   <= 1'b0;
      pend_rdata_q <= {DATA_W{1'b0}};
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_err_q   <= pend_err_d;
      pend_rdata_q <= pend_rdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Byte-enabled array write on the handshake edge; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_en_s && be_s[b]) begin
        mem_q[idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule
